// File: rtl/acsp_pkg.sv
// Shared opcodes, state and trigger-register encodings for the ACSP command decoder.
package acsp_pkg;

    localparam logic [7:0] OP_RESET      = 8'h00;
    localparam logic [7:0] OP_ARM        = 8'h01;
    localparam logic [7:0] OP_ID         = 8'h02;
    localparam logic [7:0] OP_META       = 8'h04;
    localparam logic [7:0] OP_DIVIDER    = 8'h80;
    localparam logic [7:0] OP_READ_DELAY = 8'h81;
    localparam logic [7:0] OP_FLAGS      = 8'h82;
    localparam logic [7:0] OP_TRIG_BASE  = 8'hC0;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        TRIG_RISE  = 2'd0,
        TRIG_FALL  = 2'd1,
        TRIG_MASK  = 2'd2,
        TRIG_VALUE = 2'd3
    } trig_reg_e;

    // Trigger opcodes occupy 0xC0..0xCF: high nibble matches, low nibble is {stage, reg}.
    function automatic logic is_trig_op(input logic [7:0] op);
        return op[7:4] == OP_TRIG_BASE[7:4];
    endfunction

endpackage

// File: rtl/acsp_cmd_timeout.sv
// Counts idle clocks while a long command is in progress; expired marks the last idle clock allowed.
module acsp_cmd_timeout
    import acsp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic system_clock,
    input  logic ext_reset_n,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] idle_count;

    // A byte arriving in the would-be expiry cycle suppresses expiry and restarts the count.
    assign expired = enable && !kick && (idle_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            idle_count <= '0;
        end else if (!enable || kick || expired) begin
            idle_count <= '0;
        end else begin
            idle_count <= idle_count + CW'(1);
        end
    end

endmodule

// File: rtl/acsp_cmd_decoder.sv
// SUMP-style byte command decoder: short-command strobes plus capture configuration registers.
// Optional inter-byte timeout is compiled in with ACSP_CMD_TIMEOUT_EN.
module acsp_cmd_decoder
    import acsp_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = 8,
    parameter int TRIG_STAGES    = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                                      system_clock,
    input  logic                                      ext_reset_n,
    input  logic [7:0]                                rx_data,
    input  logic                                      rx_valid,
    output logic                                      reset_pulse,
    output logic                                      arm_pulse,
    output logic                                      id_req_pulse,
    output logic                                      meta_req_pulse,
    output logic                                      cfg_update,
    output logic                                      unknown_cmd,
    output logic                                      cmd_timeout,
    output logic [23:0]                               divider,
    output logic [15:0]                               read_count,
    output logic [15:0]                               delay_count,
    output logic [31:0]                               flags,
    output logic [TRIG_STAGES-1:0][SAMPLE_WIDTH-1:0]  trig_rise,
    output logic [TRIG_STAGES-1:0][SAMPLE_WIDTH-1:0]  trig_fall,
    output logic [TRIG_STAGES-1:0][SAMPLE_WIDTH-1:0]  trig_mask,
    output logic [TRIG_STAGES-1:0][SAMPLE_WIDTH-1:0]  trig_value,
    output logic                                      dbg_state
);

    state_e      state;
    logic [7:0]  opcode;
    logic [1:0]  payload_count;
    logic [23:0] payload_shift;
    logic [31:0] word;
    logic        timeout_expired;

    // The fourth payload byte is used straight from rx_data, completing the word MSB-first.
    assign word      = {payload_shift, rx_data};
    assign dbg_state = state;

`ifdef ACSP_CMD_TIMEOUT_EN
    acsp_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .system_clock (system_clock),
        .ext_reset_n  (ext_reset_n),
        .enable       (state == ST_PAYLOAD),
        .kick         (rx_valid),
        .expired      (timeout_expired)
    );
`else
    // Without the timeout the parameter has no effect; this keeps it referenced.
    assign timeout_expired = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state          <= ST_IDLE;
            opcode         <= '0;
            payload_count  <= '0;
            payload_shift  <= '0;
            reset_pulse    <= 1'b0;
            arm_pulse      <= 1'b0;
            id_req_pulse   <= 1'b0;
            meta_req_pulse <= 1'b0;
            cfg_update     <= 1'b0;
            unknown_cmd    <= 1'b0;
            cmd_timeout    <= 1'b0;
            divider        <= '0;
            read_count     <= '0;
            delay_count    <= '0;
            flags          <= '0;
            trig_rise      <= '0;
            trig_fall      <= '0;
            trig_mask      <= '0;
            trig_value     <= '0;
        end else begin
            reset_pulse    <= 1'b0;
            arm_pulse      <= 1'b0;
            id_req_pulse   <= 1'b0;
            meta_req_pulse <= 1'b0;
            cfg_update     <= 1'b0;
            unknown_cmd    <= 1'b0;
            cmd_timeout    <= 1'b0;

            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data[7]) begin
                            opcode        <= rx_data;
                            payload_count <= '0;
                            state         <= ST_PAYLOAD;
                        end else begin
                            case (rx_data)
                                OP_RESET: reset_pulse    <= 1'b1;
                                OP_ARM:   arm_pulse      <= 1'b1;
                                OP_ID:    id_req_pulse   <= 1'b1;
                                OP_META:  meta_req_pulse <= 1'b1;
                                default:  unknown_cmd    <= 1'b1;
                            endcase
                        end
                    end
                    ST_PAYLOAD: begin
                        if (payload_count == 2'd3) begin
                            state <= ST_IDLE;
                            if (opcode == OP_DIVIDER) begin
                                divider    <= word[23:0];
                                cfg_update <= 1'b1;
                            end else if (opcode == OP_READ_DELAY) begin
                                read_count  <= word[31:16];
                                delay_count <= word[15:0];
                                cfg_update  <= 1'b1;
                            end else if (opcode == OP_FLAGS) begin
                                flags      <= word;
                                cfg_update <= 1'b1;
                            end else if (is_trig_op(opcode) && int'(opcode[3:2]) < TRIG_STAGES) begin
                                cfg_update <= 1'b1;
                                for (int s = 0; s < TRIG_STAGES; s++) begin
                                    if (int'(opcode[3:2]) == s) begin
                                        case (trig_reg_e'(opcode[1:0]))
                                            TRIG_RISE:  trig_rise[s]  <= word[SAMPLE_WIDTH-1:0];
                                            TRIG_FALL:  trig_fall[s]  <= word[SAMPLE_WIDTH-1:0];
                                            TRIG_MASK:  trig_mask[s]  <= word[SAMPLE_WIDTH-1:0];
                                            TRIG_VALUE: trig_value[s] <= word[SAMPLE_WIDTH-1:0];
                                        endcase
                                    end
                                end
                            end else begin
                                unknown_cmd <= 1'b1;
                            end
                        end else begin
                            payload_shift <= {payload_shift[15:0], rx_data};
                            payload_count <= payload_count + 2'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (timeout_expired) begin
                state       <= ST_IDLE;
                cmd_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acsp_cmd_decoder.sv
// Bench for acsp_cmd_decoder: vector table, hand-written corner sequences, random commands vs a queue-based model.
// Timeout checks follow ACSP_CMD_TIMEOUT_EN when it is defined for the build.
module tb_acsp_cmd_decoder;

    localparam int SW = 8;
    localparam int TS = 2;
    localparam int TO = 50;

    logic               system_clock = 1'b0;
    logic               ext_reset_n;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               reset_pulse, arm_pulse, id_req_pulse, meta_req_pulse;
    logic               cfg_update, unknown_cmd, cmd_timeout;
    logic [23:0]        divider;
    logic [15:0]        read_count, delay_count;
    logic [31:0]        flags;
    logic [TS-1:0][SW-1:0] trig_rise, trig_fall, trig_mask, trig_value;
    logic               dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 system_clock = ~system_clock;

    acsp_cmd_decoder #(
        .SAMPLE_WIDTH   (SW),
        .TRIG_STAGES    (TS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .system_clock   (system_clock),
        .ext_reset_n    (ext_reset_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .reset_pulse    (reset_pulse),
        .arm_pulse      (arm_pulse),
        .id_req_pulse   (id_req_pulse),
        .meta_req_pulse (meta_req_pulse),
        .cfg_update     (cfg_update),
        .unknown_cmd    (unknown_cmd),
        .cmd_timeout    (cmd_timeout),
        .divider        (divider),
        .read_count     (read_count),
        .delay_count    (delay_count),
        .flags          (flags),
        .trig_rise      (trig_rise),
        .trig_fall      (trig_fall),
        .trig_mask      (trig_mask),
        .trig_value     (trig_value),
        .dbg_state      (dbg_state)
    );

    // Strobe vector bit order: {reset, arm, id, meta, cfg, unknown, timeout}
    localparam logic [6:0] S_RST = 7'b1000000;
    localparam logic [6:0] S_ARM = 7'b0100000;
    localparam logic [6:0] S_ID  = 7'b0010000;
    localparam logic [6:0] S_MET = 7'b0001000;
    localparam logic [6:0] S_CFG = 7'b0000100;
    localparam logic [6:0] S_UNK = 7'b0000010;
    localparam logic [6:0] S_TMO = 7'b0000001;
    localparam logic [6:0] S_NONE = 7'b0000000;

    // ---------------- reference model ----------------
    logic [7:0]  pend[$];
    int          idle_cnt;
    logic [23:0] m_div;
    logic [15:0] m_rc, m_dc;
    logic [31:0] m_flags;
    logic [7:0]  m_trig[4][TS];   // [register][stage]

    task automatic model_reset();
        pend.delete();
        idle_cnt = 0;
        m_div = '0; m_rc = '0; m_dc = '0; m_flags = '0;
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < TS; s++)
                m_trig[r][s] = '0;
    endtask

    function automatic logic [6:0] model_byte(input logic [7:0] b);
        logic [31:0] w;
        logic [7:0]  op;
        int          s, r;
        idle_cnt = 0;
        if (pend.size() == 0 && b < 8'h80) begin
            case (b)
                8'h00:   return S_RST;
                8'h01:   return S_ARM;
                8'h02:   return S_ID;
                8'h04:   return S_MET;
                default: return S_UNK;
            endcase
        end
        pend.push_back(b);
        if (pend.size() < 5) return S_NONE;
        op = pend[0];
        w  = {pend[1], pend[2], pend[3], pend[4]};
        pend.delete();
        if (op == 8'h80) begin m_div = w[23:0]; return S_CFG; end
        if (op == 8'h81) begin m_rc = w[31:16]; m_dc = w[15:0]; return S_CFG; end
        if (op == 8'h82) begin m_flags = w; return S_CFG; end
        if (op >= 8'hC0 && op <= 8'hCF) begin
            s = (int'(op) - 'hC0) / 4;
            r = (int'(op) - 'hC0) % 4;
            if (s < TS) begin
                m_trig[r][s] = w[7:0];
                return S_CFG;
            end
        end
        return S_UNK;
    endfunction

    function automatic logic [6:0] model_idle();
        if (pend.size() == 0) return S_NONE;
        idle_cnt++;
`ifdef ACSP_CMD_TIMEOUT_EN
        if (idle_cnt == TO) begin
            pend.delete();
            idle_cnt = 0;
            return S_TMO;
        end
`endif
        return S_NONE;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {reset_pulse, arm_pulse, id_req_pulse, meta_req_pulse, cfg_update, unknown_cmd, cmd_timeout};
    endfunction

    task automatic check_regs(input string tag);
        logic [TS*SW-1:0] er, ef, em, ev;
        for (int s = 0; s < TS; s++) begin
            er[s*SW +: SW] = m_trig[0][s];
            ef[s*SW +: SW] = m_trig[1][s];
            em[s*SW +: SW] = m_trig[2][s];
            ev[s*SW +: SW] = m_trig[3][s];
        end
        check({tag, "_cfg"}, {divider, read_count, delay_count, flags}, {m_div, m_rc, m_dc, m_flags});
        check({tag, "_trig"}, {trig_rise, trig_fall, trig_mask, trig_value}, {er, ef, em, ev});
    endtask

    // Called on a falling edge: drive one cycle, then sample on the next falling edge.
    task automatic step(input logic v, input logic [7:0] d, output logic [6:0] got);
        logic [6:0] exp;
        rx_valid = v;
        rx_data  = d;
        exp = v ? model_byte(d) : model_idle();
        @(posedge system_clock);
        @(negedge system_clock);
        got = strobes();
        check("strobes", got, exp);
        check_regs("regs");
        rx_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          nb;
        logic [39:0] seq;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [6:0]  got;
        logic [7:0]  b;
        logic [7:0]  op;
        logic [23:0] saved_div;

        vecs[0]  = '{"short_reset",   1, 40'h00_00000000, S_RST};
        vecs[1]  = '{"short_meta",    1, 40'h04_00000000, S_MET};
        vecs[2]  = '{"short_id",      1, 40'h02_00000000, S_ID};
        vecs[3]  = '{"short_arm",     1, 40'h01_00000000, S_ARM};
        vecs[4]  = '{"divider",       5, 40'h80_0098967F, S_CFG};
        vecs[5]  = '{"read_delay",    5, 40'h81_00030003, S_CFG};
        vecs[6]  = '{"trig_fall_s0",  5, 40'hC1_000000A5, S_CFG};
        vecs[7]  = '{"trig_stage2",   5, 40'hC9_0000005A, S_UNK};
        vecs[8]  = '{"flags",         5, 40'h82_38000000, S_CFG};
        vecs[9]  = '{"long_unknown",  5, 40'h83_11223344, S_UNK};
        vecs[10] = '{"arm_after_unk", 1, 40'h01_00000000, S_ARM};
        vecs[11] = '{"short_unk_05",  1, 40'h05_00000000, S_UNK};
        vecs[12] = '{"short_unk_7f",  1, 40'h7F_00000000, S_UNK};
        vecs[13] = '{"trig_stage3",   5, 40'hCE_12345678, S_UNK};
        vecs[14] = '{"trig_mask_s1",  5, 40'hC6_DEADBEEF, S_CFG};
        vecs[15] = '{"trig_val_zero", 5, 40'hC7_00000000, S_CFG};

        // clock/reset
        ext_reset_n = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        model_reset();
        repeat (3) @(negedge system_clock);
        check("reset_strobes", strobes(), S_NONE);
        check_regs("reset");
        check("reset_state", dbg_state, 1'b0);
        ext_reset_n = 1'b1;
        @(negedge system_clock);

        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i < vecs[v].nb; i++) begin
                b = vecs[v].seq[39 - 8*i -: 8];
                step(1'b1, b, got);
                if (i == vecs[v].nb - 1)
                    check(vecs[v].name, got, vecs[v].exp);
            end
        end

        check("divider_value", divider, 24'h98967F);
        check("read_count_value", read_count, 16'd3);
        check("delay_count_value", delay_count, 16'd3);
        check("flags_value", flags, 32'h38000000);
        check("trig_fall0", trig_fall[0], 8'hA5);
        check("trig_mask1", trig_mask[1], 8'hEF);
        check("trig_rise1_untouched", trig_rise[1], 8'h00);
        check("trig_fall1_untouched", trig_fall[1], 8'h00);

        // inter-byte silence
        saved_div = m_div;
        step(1'b1, 8'h80, got);
        step(1'b1, 8'h11, got);
        check("state_payload", dbg_state, 1'b1);
        step(1'b1, 8'h22, got);
`ifdef ACSP_CMD_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            step(1'b0, 8'h00, got);
            if (i == TO - 1) check("timeout_not_early", got[0], 1'b0);
            if (i == TO)     check("timeout_fires", got[0], 1'b1);
        end
        check("timeout_state_idle", dbg_state, 1'b0);
        check("timeout_div_kept", divider, saved_div);
        step(1'b1, 8'h01, got);
        check("arm_after_timeout", got, S_ARM);
        // byte arriving in the expiry cycle is accepted
        step(1'b1, 8'h80, got);
        step(1'b1, 8'h11, got);
        for (int i = 1; i < TO; i++) step(1'b0, 8'h00, got);
        step(1'b1, 8'h22, got);
        check("expiry_byte_wins", got[0], 1'b0);
        step(1'b1, 8'h33, got);
        step(1'b1, 8'h44, got);
        check("expiry_cmd_done", got, S_CFG);
        check("expiry_divider", divider, 24'h223344);
`else
        for (int i = 1; i <= TO + 10; i++) step(1'b0, 8'h00, got);
        check("no_timeout_state", dbg_state, 1'b1);
        check("no_timeout_div_kept", divider, saved_div);
        step(1'b1, 8'h33, got);
        step(1'b1, 8'h44, got);
        check("late_cmd_done", got, S_CFG);
        check("late_divider", divider, 24'h223344);
`endif

        // random commands
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom_range(0, 127));
                step(1'b1, b, got);
            end else begin
                case ($urandom_range(0, 4))
                    0:       op = 8'h80;
                    1:       op = 8'h81;
                    2:       op = 8'h82;
                    3:       op = 8'(8'hC0 + $urandom_range(0, 15));
                    default: op = 8'($urandom_range(128, 255));
                endcase
                step(1'b1, op, got);
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) step(1'b0, 8'h00, got);
                    step(1'b1, 8'($urandom), got);
                end
            end
        end

        // asynchronous reset in the middle of a long command
        step(1'b1, 8'h80, got);
        step(1'b1, 8'h11, got);
        #2 ext_reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_reset_strobes", strobes(), S_NONE);
        check("mid_reset_state", dbg_state, 1'b0);
        check_regs("mid_reset");
        @(negedge system_clock);
        ext_reset_n = 1'b1;
        @(negedge system_clock);
        step(1'b1, 8'h00, got);
        check("reset_then_short", got, S_RST);
        check("reset_then_idle", dbg_state, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
